core_pipe_ctrl: RTL and testbench

//  Parametrised pipeline controller for the RV32 core; successor of the fixed single-request core controller.

---
 rtl/core_pipe_ctrl_if.sv | 34 +++
 rtl/core_pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_core_pipe_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pipe_ctrl_if.sv
// Handshake/bus bundle between core_pipe_ctrl and the EX/exception logic, PC and pipeline registers.
// master = the controller; slave = the surrounding pipeline.
interface core_pipe_ctrl_if #(
    parameter int unsigned STALL_REQ_NUM = 1,
    parameter int unsigned STAGE_NUM     = 3
);
    logic [STALL_REQ_NUM-1:0] stall_req;
    logic                     jump_req;
    logic [31:0]              jump_addr;
    logic                     trap_req;
    logic [31:0]              trap_addr;
    logic                     wfi;
    logic                     int_pending;
    logic                     stall_n;
    logic [STAGE_NUM-1:0]     flush;
    logic                     pc_load;
    logic [31:0]              pc_load_addr;
    logic                     flushing;
    logic                     redirect_pending;
    logic                     sleeping;
    logic                     stall_timeout;

    modport master (
        input  stall_req, jump_req, jump_addr, trap_req, trap_addr, wfi, int_pending,
        output stall_n, flush, pc_load, pc_load_addr, flushing, redirect_pending, sleeping,
               stall_timeout
    );

    modport slave (
        output stall_req, jump_req, jump_addr, trap_req, trap_addr, wfi, int_pending,
        input  stall_n, flush, pc_load, pc_load_addr, flushing, redirect_pending, sleeping,
               stall_timeout
    );
endinterface

// File: rtl/core_pipe_ctrl.sv
// RV32 pipeline controller: stall merge, redirect serialisation, flush timing and WFI sleep.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
module core_pipe_ctrl #(
    parameter int unsigned STALL_REQ_NUM = 1,
    parameter int unsigned STAGE_NUM     = 3,
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    core_pipe_ctrl_if.master   ctrl_io
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {RUN, STALL, FLUSH, SLEEP} state_e;

    typedef struct packed {
        logic        trap;
        logic [31:0] addr;
    } redir_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             pc_load_q, pc_load_d;
    logic [31:0]      pc_addr_q, pc_addr_d;
    logic             pend_q, pend_d;
    redir_t           pend_red_q, pend_red_d;

    logic   stall_any_c, sleeping_c, new_v_c, cand_v_c, go_c;
    redir_t new_red_c, cand_red_c;

    // Merge the incoming redirect with a deferred one; a jump never displaces a pending trap.
    always_comb begin
        stall_any_c    = |ctrl_io.stall_req;
        sleeping_c     = (state_q == SLEEP);
        new_v_c        = ctrl_io.trap_req | (ctrl_io.jump_req & ~sleeping_c);
        new_red_c.trap = ctrl_io.trap_req;
        new_red_c.addr = ctrl_io.trap_req ? ctrl_io.trap_addr : ctrl_io.jump_addr;
        cand_v_c       = new_v_c | pend_q;
        cand_red_c     = pend_red_q;
        if (new_v_c && (new_red_c.trap || !pend_q || !pend_red_q.trap)) begin
            cand_red_c = new_red_c;
        end
        go_c = cand_v_c & ~stall_any_c;
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_load_d  = 1'b0;
        pc_addr_d  = pc_addr_q;
        pend_d     = pend_q;
        pend_red_d = pend_red_q;

        // Flush counter freezes while the pipeline is stalled.
        if ((fcnt_q != '0) && !stall_any_c) begin
            fcnt_d = fcnt_q - CNT_W'(1);
        end

        if (go_c) begin
            pc_load_d = 1'b1;
            pc_addr_d = cand_red_c.addr;
            fcnt_d    = CNT_W'(FLUSH_CYCLES);
            pend_d    = 1'b0;
            state_d   = FLUSH;
        end else if (cand_v_c) begin
            pend_d     = 1'b1;
            pend_red_d = cand_red_c;
            state_d    = STALL;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_any_c) begin
                        state_d = STALL;
                    end else if (ctrl_io.wfi && !ctrl_io.int_pending) begin
                        state_d = SLEEP;
                    end
                end
                STALL: begin
                    if (!stall_any_c) begin
                        state_d = (fcnt_d != '0) ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
                    if (fcnt_d == '0) begin
                        state_d = RUN;
                    end
                end
                SLEEP: begin
                    if (ctrl_io.int_pending) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            pc_load_q  <= 1'b0;
            pc_addr_q  <= '0;
            pend_q     <= 1'b0;
            pend_red_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pc_load_q  <= pc_load_d;
            pc_addr_q  <= pc_addr_d;
            pend_q     <= pend_d;
            pend_red_q <= pend_red_d;
        end
    end

`ifdef STALL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(STALL_TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    // Consecutive-stall counter, saturating at the limit; timeout flag is sticky.
    always_comb begin
        wd_d = '0;
        if (stall_any_c) begin
            wd_d = (wd_q == WD_W'(STALL_TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        end
        to_d = to_q | (wd_d == WD_W'(STALL_TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign ctrl_io.stall_timeout = to_q;
`else
    assign ctrl_io.stall_timeout = 1'b0 & (STALL_TIMEOUT != 0);
`endif

    assign ctrl_io.stall_n          = ~stall_any_c & ~sleeping_c;
    assign ctrl_io.flushing         = (fcnt_q != '0);
    assign ctrl_io.flush            = {STAGE_NUM{ctrl_io.flushing}};
    assign ctrl_io.pc_load          = pc_load_q;
    assign ctrl_io.pc_load_addr     = pc_addr_q;
    assign ctrl_io.redirect_pending = pend_q;
    assign ctrl_io.sleeping         = sleeping_c;
endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed self-checking bench for core_pipe_ctrl (STALL_REQ_NUM=2, FLUSH_CYCLES=2, STALL_TIMEOUT=8).
module tb_core_pipe_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    core_pipe_ctrl_if #(.STALL_REQ_NUM(2), .STAGE_NUM(3)) bus ();

    core_pipe_ctrl #(
        .STALL_REQ_NUM(2),
        .STAGE_NUM    (3),
        .FLUSH_CYCLES (2),
        .STALL_TIMEOUT(8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.stall_req   = 2'b00;
        bus.jump_req    = 1'b0;
        bus.jump_addr   = 32'h0;
        bus.trap_req    = 1'b0;
        bus.trap_addr   = 32'h0;
        bus.wfi         = 1'b0;
        bus.int_pending = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_inputs();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({bus.stall_n, bus.flush, bus.pc_load, bus.flushing, bus.redirect_pending,
             bus.sleeping, bus.stall_timeout} !== 9'b1_000_0_0_0_0_0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {bus.stall_n, bus.flush, bus.pc_load,
                     bus.flushing, bus.redirect_pending, bus.sleeping, bus.stall_timeout},
                     9'b1_000_0_0_0_0_0);
        end
        checks++;
        if (bus.pc_load_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", bus.pc_load_addr, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.stall_req = 2'b10;
            #1;
            checks++;
            if (bus.stall_n !== 1'b0 || bus.pc_load !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d stall_n=%b pc_load=%b exp stall_n=0 pc_load=0",
                         c, bus.stall_n, bus.pc_load);
            end
        end
        @(negedge clk);
        bus.stall_req = 2'b00;
        #1;
        checks++;
        if (bus.stall_n !== 1'b1 || bus.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL stall_release stall_n=%b pc_load=%b exp stall_n=1 pc_load=0",
                     bus.stall_n, bus.pc_load);
        end
        idle(2);
    endtask

    task automatic test_jump();
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h0000_0100;
        #1;
        checks++;
        if (bus.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL jump_early pc_load got=%b exp=0", bus.pc_load);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h100 || bus.flush !== 3'b111) begin
            failures++;
            $display("FAIL jump_load pc_load=%b addr=%h flush=%b exp 1 00000100 111",
                     bus.pc_load, bus.pc_load_addr, bus.flush);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.pc_load !== 1'b0 || bus.flush !== 3'b111 || bus.flushing !== 1'b1) begin
            failures++;
            $display("FAIL jump_flush2 pc_load=%b flush=%b flushing=%b exp 0 111 1",
                     bus.pc_load, bus.flush, bus.flushing);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.flush !== 3'b000 || bus.flushing !== 1'b0) begin
            failures++;
            $display("FAIL jump_flush_end flush=%b flushing=%b exp 000 0", bus.flush, bus.flushing);
        end
    endtask

    task automatic test_trap_priority();
        @(negedge clk);
        bus.trap_req  = 1'b1;
        bus.trap_addr = 32'h8;
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h100;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h8) begin
            failures++;
            $display("FAIL trap_prio pc_load=%b addr=%h exp 1 00000008", bus.pc_load, bus.pc_load_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.pc_load !== 1'b0 || bus.pc_load_addr !== 32'h8) begin
            failures++;
            $display("FAIL trap_single pc_load=%b addr=%h exp 0 00000008", bus.pc_load, bus.pc_load_addr);
        end
        idle(2);
    endtask

    task automatic test_pending();
        @(negedge clk);
        bus.stall_req = 2'b01;
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h40;
        @(negedge clk);
        bus.jump_req = 1'b0;
        #1;
        checks++;
        if (bus.redirect_pending !== 1'b1 || bus.pc_load !== 1'b0 || bus.stall_n !== 1'b0) begin
            failures++;
            $display("FAIL pend_latch pending=%b pc_load=%b stall_n=%b exp 1 0 0",
                     bus.redirect_pending, bus.pc_load, bus.stall_n);
        end
        @(negedge clk);
        bus.stall_req = 2'b00;
        #1;
        checks++;
        if (bus.pc_load !== 1'b0 || bus.stall_n !== 1'b1) begin
            failures++;
            $display("FAIL pend_release pc_load=%b stall_n=%b exp 0 1", bus.pc_load, bus.stall_n);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h40 || bus.redirect_pending !== 1'b0) begin
            failures++;
            $display("FAIL pend_apply pc_load=%b addr=%h pending=%b exp 1 00000040 0",
                     bus.pc_load, bus.pc_load_addr, bus.redirect_pending);
        end
        idle(3);
    endtask

    // order 0: trap then jump (jump must not overwrite); order 1: jump then trap (trap overwrites)
    task automatic test_pending_priority();
        for (int order = 0; order < 2; order++) begin
            @(negedge clk);
            bus.stall_req = 2'b11;
            @(negedge clk);
            bus.trap_req  = (order == 0);
            bus.jump_req  = (order == 1);
            bus.trap_addr = 32'h200;
            bus.jump_addr = 32'h300;
            @(negedge clk);
            bus.trap_req = (order == 1);
            bus.jump_req = (order == 0);
            @(negedge clk);
            idle_inputs();
            @(negedge clk);
            #1;
            checks++;
            if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h200) begin
                failures++;
                $display("FAIL pend_prio%0d pc_load=%b addr=%h exp 1 00000200",
                         order, bus.pc_load, bus.pc_load_addr);
            end
            idle(3);
        end
    endtask

    task automatic test_flush_restart();
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h100;
        @(negedge clk);
        bus.jump_addr = 32'h200;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h200 || bus.flush !== 3'b111) begin
            failures++;
            $display("FAIL restart_load pc_load=%b addr=%h flush=%b exp 1 00000200 111",
                     bus.pc_load, bus.pc_load_addr, bus.flush);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.flushing !== 1'b1) begin
            failures++;
            $display("FAIL restart_flush2 flushing got=%b exp=1", bus.flushing);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.flushing !== 1'b0) begin
            failures++;
            $display("FAIL restart_end flushing got=%b exp=0", bus.flushing);
        end
    endtask

    task automatic test_flush_freeze();
        logic exp_fl [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] stl [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_inputs();
            bus.stall_req = stl[c];
            #1;
            checks++;
            if (bus.flushing !== exp_fl[c]) begin
                failures++;
                $display("FAIL freeze_cycle%0d flushing got=%b exp=%b", c, bus.flushing, exp_fl[c]);
            end
        end
        idle(1);
    endtask

    task automatic test_wfi();
        @(negedge clk);
        bus.wfi = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if (bus.sleeping !== 1'b1 || bus.stall_n !== 1'b0) begin
                failures++;
                $display("FAIL sleep_cycle%0d sleeping=%b stall_n=%b exp 1 0", c, bus.sleeping, bus.stall_n);
            end
        end
        @(negedge clk);
        bus.int_pending = 1'b1;
        #1;
        checks++;
        if (bus.sleeping !== 1'b1) begin
            failures++;
            $display("FAIL wake_same sleeping got=%b exp=1", bus.sleeping);
        end
        @(negedge clk);
        bus.int_pending = 1'b0;
        #1;
        checks++;
        if (bus.sleeping !== 1'b0 || bus.stall_n !== 1'b1 || bus.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL wake_next sleeping=%b stall_n=%b pc_load=%b exp 0 1 0",
                     bus.sleeping, bus.stall_n, bus.pc_load);
        end
        @(negedge clk);
        bus.wfi         = 1'b1;
        bus.int_pending = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.sleeping !== 1'b0 || bus.stall_n !== 1'b1) begin
            failures++;
            $display("FAIL wfi_nop sleeping=%b stall_n=%b exp 0 1", bus.sleeping, bus.stall_n);
        end
    endtask

    task automatic test_sleep_trap();
        @(negedge clk);
        bus.wfi = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.trap_req  = 1'b1;
        bus.trap_addr = 32'h80;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.sleeping !== 1'b0 || bus.pc_load !== 1'b1 || bus.pc_load_addr !== 32'h80) begin
            failures++;
            $display("FAIL sleep_trap sleeping=%b pc_load=%b addr=%h exp 0 1 00000080",
                     bus.sleeping, bus.pc_load, bus.pc_load_addr);
        end
        idle(3);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 32'h100;
        @(negedge clk);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pc_load !== 1'b0 || bus.flushing !== 1'b0 || bus.pc_load_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_abort pc_load=%b flushing=%b addr=%h exp 0 0 00000000",
                     bus.pc_load, bus.flushing, bus.pc_load_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_watchdog();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.stall_req = 2'b01;
            #1;
            checks++;
            if (bus.stall_timeout !== 1'b0) begin
                failures++;
                $display("FAIL wd_early%0d stall_timeout got=%b exp=0", c, bus.stall_timeout);
            end
        end
        @(negedge clk);
        bus.stall_req = 2'b00;
        #1;
`ifdef STALL_WATCHDOG_EN
        checks++;
        if (bus.stall_timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_set stall_timeout got=%b exp=1", bus.stall_timeout);
        end
        idle(3);
        checks++;
        if (bus.stall_timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_sticky stall_timeout got=%b exp=1", bus.stall_timeout);
        end
`else
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL wd_off stall_timeout got=%b exp=0", bus.stall_timeout);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stall();
        test_jump();
        test_trap_priority();
        test_pending();
        test_pending_priority();
        test_flush_restart();
        test_flush_freeze();
        test_wfi();
        test_sleep_trap();
        test_reset_abort();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
